// File: rtl/mig_rw_arbiter_pkg.sv
// rtl/mig_rw_arbiter_pkg.sv - shared types and constants for the MIG read/write arbiter
package mig_rw_arbiter_pkg;

    localparam int DEF_ADDR_W    = 28;
    localparam int DEF_DATA_W    = 128;
    localparam int DEF_LEN_W     = 8;
    localparam int DEF_ADDR_STEP = 8;

    localparam logic [2:0] MIG_CMD_WR = 3'b000;
    localparam logic [2:0] MIG_CMD_RD = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_DONE = 2'd3
    } arb_state_t;

    typedef enum logic {
        G_WR = 1'b0,
        G_RD = 1'b1
    } grant_t;

endpackage

// File: rtl/mig_rw_arbiter_if.sv
// rtl/mig_rw_arbiter_if.sv - user request streams plus MIG native UI signals
interface mig_rw_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int LEN_W  = 8
);
    logic                  init_calib_complete;

    logic                  wr_req;
    logic [ADDR_W-1:0]     wr_addr;
    logic [LEN_W-1:0]      wr_len;
    logic [DATA_W-1:0]     wr_data;
    logic                  wr_data_rd;
    logic                  wr_done;

    logic                  rd_req;
    logic [ADDR_W-1:0]     rd_addr;
    logic [LEN_W-1:0]      rd_len;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_data_vld;
    logic                  rd_done;

    logic [ADDR_W-1:0]     app_addr;
    logic [2:0]            app_cmd;
    logic                  app_en;
    logic                  app_rdy;
    logic [DATA_W-1:0]     app_wdf_data;
    logic                  app_wdf_wren;
    logic                  app_wdf_end;
    logic [DATA_W/8-1:0]   app_wdf_mask;
    logic                  app_wdf_rdy;
    logic [DATA_W-1:0]     app_rd_data;
    logic                  app_rd_data_valid;

    modport slave (
        input  init_calib_complete,
        input  wr_req, wr_addr, wr_len, wr_data,
        output wr_data_rd, wr_done,
        input  rd_req, rd_addr, rd_len,
        output rd_data, rd_data_vld, rd_done,
        output app_addr, app_cmd, app_en,
        input  app_rdy,
        output app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
        input  app_wdf_rdy,
        input  app_rd_data, app_rd_data_valid
    );

    modport master (
        output init_calib_complete,
        output wr_req, wr_addr, wr_len, wr_data,
        input  wr_data_rd, wr_done,
        output rd_req, rd_addr, rd_len,
        input  rd_data, rd_data_vld, rd_done,
        input  app_addr, app_cmd, app_en,
        output app_rdy,
        input  app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
        output app_wdf_rdy,
        output app_rd_data, app_rd_data_valid
    );

endinterface

// File: rtl/mig_rw_arbiter_burst_ctr.sv
// rtl/mig_rw_arbiter_burst_ctr.sv - beat counter: load length, step on handshake, flag count == length
module mig_rw_arbiter_burst_ctr #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             step_i,
    output logic             done_o
);

    // One extra bit so a full-length burst never wraps the counter.
    logic [LEN_W:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;

    assign done_o = (cnt_q == {1'b0, len_q});

    always_comb begin
        cnt_d = cnt_q;
        len_d = len_q;
        if (load_i) begin
            cnt_d = '0;
            len_d = len_i;
        end else if (step_i && !done_o) begin
            cnt_d = cnt_q + (LEN_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            len_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            len_q <= len_d;
        end
    end

endmodule

// File: rtl/mig_rw_arbiter.sv
// rtl/mig_rw_arbiter.sv - round-robin write/read burst scheduler in front of the MIG native UI
module mig_rw_arbiter
    import mig_rw_arbiter_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int LEN_W     = DEF_LEN_W,
    parameter int ADDR_STEP = DEF_ADDR_STEP
) (
    input  logic              sysclk,
    input  logic              rst_n,
    mig_rw_arbiter_if.slave   bus
);

    arb_state_t        state_q, state_d;
    grant_t            last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              load;
    logic [LEN_W-1:0]  len_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic              pick_wr;
    logic              in_wr, in_rd;
    logic              cmd_done, data_done;
    logic              cmd_step, data_step;
    logic              app_en_w, wdf_wren_w;

    assign pick_wr = bus.wr_req && (!bus.rd_req || (last_q == G_RD));

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        load     = 1'b0;
        addr_sel = bus.wr_addr;
        len_sel  = bus.wr_len;
        case (state_q)
            S_IDLE: begin
                if (bus.init_calib_complete && (bus.wr_req || bus.rd_req)) begin
                    load = 1'b1;
                    if (pick_wr) begin
                        last_d   = G_WR;
                        addr_sel = bus.wr_addr;
                        len_sel  = bus.wr_len;
                        state_d  = (bus.wr_len == '0) ? S_DONE : S_WR;
                    end else begin
                        last_d   = G_RD;
                        addr_sel = bus.rd_addr;
                        len_sel  = bus.rd_len;
                        state_d  = (bus.rd_len == '0) ? S_DONE : S_RD;
                    end
                end
            end
            S_WR, S_RD: begin
                if (cmd_done && data_done) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign in_wr      = (state_q == S_WR);
    assign in_rd      = (state_q == S_RD);
    assign app_en_w   = (in_wr || in_rd) && !cmd_done;
    assign wdf_wren_w = in_wr && !data_done;
    assign cmd_step   = app_en_w && bus.app_rdy;
    assign data_step  = (wdf_wren_w && bus.app_wdf_rdy) ||
                        (in_rd && bus.app_rd_data_valid);

    // Address only moves on an accepted command, so it stays put while app_rdy is low.
    always_comb begin
        addr_d = addr_q;
        if (load)          addr_d = addr_sel;
        else if (cmd_step) addr_d = addr_q + ADDR_W'(ADDR_STEP);
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            last_q  <= G_RD;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
        end
    end

    mig_rw_arbiter_burst_ctr #(.LEN_W(LEN_W)) u_cmd_ctr (
        .clk    (sysclk),
        .rst_n  (rst_n),
        .load_i (load),
        .len_i  (len_sel),
        .step_i (cmd_step),
        .done_o (cmd_done)
    );

    mig_rw_arbiter_burst_ctr #(.LEN_W(LEN_W)) u_data_ctr (
        .clk    (sysclk),
        .rst_n  (rst_n),
        .load_i (load),
        .len_i  (len_sel),
        .step_i (data_step),
        .done_o (data_done)
    );

    assign bus.app_en       = app_en_w;
    assign bus.app_cmd      = in_rd ? MIG_CMD_RD : MIG_CMD_WR;
    assign bus.app_addr     = addr_q;
    assign bus.app_wdf_wren = wdf_wren_w;
    assign bus.app_wdf_end  = wdf_wren_w;
    assign bus.app_wdf_data = wdf_wren_w ? bus.wr_data : '0;
    assign bus.app_wdf_mask = '0;
    assign bus.wr_data_rd   = wdf_wren_w && bus.app_wdf_rdy;
    assign bus.rd_data      = in_rd ? bus.app_rd_data : '0;
    assign bus.rd_data_vld  = in_rd && bus.app_rd_data_valid;
    assign bus.wr_done      = (state_q == S_DONE) && (last_q == G_WR);
    assign bus.rd_done      = (state_q == S_DONE) && (last_q == G_RD);

endmodule

// File: tb/tb_mig_rw_arbiter.sv
// tb/tb_mig_rw_arbiter.sv - directed bench for mig_rw_arbiter with a MIG UI stub
module tb_mig_rw_arbiter;

    logic sysclk = 1'b0;
    logic rst_n;
    always #5 sysclk = ~sysclk;

    mig_rw_arbiter_if #(.ADDR_W(28), .DATA_W(128), .LEN_W(8)) bus ();

    mig_rw_arbiter #(.ADDR_W(28), .DATA_W(128), .LEN_W(8), .ADDR_STEP(8)) dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [127:0] wpat(input int i);
        return {96'h0, 32'hD000_0000 + 32'(i)};
    endfunction

    // UI stub and monitor state
    bit                rand_rdy = 1'b0;
    bit                pop_pending = 1'b0;
    bit                stall_prev = 1'b0;
    logic [27:0]       stall_addr;
    int                wpop = 0;
    int                cmd_n = 0, pop_n = 0, en_seen = 0, hold_err = 0;
    int                wr_done_n = 0, rd_done_n = 0;
    logic [31:0]       ord = '0;
    logic [27:0]       cmd_q[$];
    logic [127:0]      rcap[$];
    logic [27:0]       waq[$];
    logic [127:0]      wdq[$];
    logic [127:0]      rdq[$];
    logic [127:0]      mem[logic [27:0]];

    always @(negedge sysclk) begin
        if (pop_pending) begin
            wpop++;
            pop_pending = 1'b0;
        end
        bus.wr_data = wpat(wpop);
        if (rand_rdy) begin
            bus.app_rdy     = 1'($urandom_range(0, 1));
            bus.app_wdf_rdy = 1'($urandom_range(0, 1));
        end else begin
            bus.app_rdy     = 1'b1;
            bus.app_wdf_rdy = 1'b1;
        end
        if (rdq.size() > 0) begin
            bus.app_rd_data       = rdq.pop_front();
            bus.app_rd_data_valid = 1'b1;
        end else begin
            bus.app_rd_data       = '0;
            bus.app_rd_data_valid = 1'b0;
        end
        #1;
        if (!rst_n) begin
            waq.delete(); wdq.delete(); rdq.delete();
            stall_prev = 1'b0;
        end else begin
            if (bus.app_en) en_seen++;
            if (stall_prev && (!bus.app_en || bus.app_addr !== stall_addr)) hold_err++;
            stall_prev = bus.app_en && !bus.app_rdy;
            stall_addr = bus.app_addr;
            if (bus.app_en && bus.app_rdy) begin
                cmd_n++;
                cmd_q.push_back(bus.app_addr);
                if (bus.app_cmd == 3'b001)
                    rdq.push_back(mem.exists(bus.app_addr) ? mem[bus.app_addr] : 128'h0);
                else
                    waq.push_back(bus.app_addr);
            end
            if (bus.wr_data_rd) begin
                pop_n++;
                pop_pending = 1'b1;
                wdq.push_back(bus.app_wdf_data);
            end
            while (waq.size() > 0 && wdq.size() > 0) mem[waq.pop_front()] = wdq.pop_front();
            if (bus.rd_data_vld) rcap.push_back(bus.rd_data);
            if (bus.wr_done) begin wr_done_n++; ord = {ord[23:0], 8'h57}; end
            if (bus.rd_done) begin rd_done_n++; ord = {ord[23:0], 8'h52}; end
        end
    end

    task automatic cyc();
        @(negedge sysclk);
        #2;
    endtask

    task automatic do_reset();
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    // Waits for the next done pulse of one requester, then drops its request.
    task automatic wait_done(input bit is_wr, input int budget, input string tag);
        int  c0;
        bit  hit;
        c0  = is_wr ? wr_done_n : rd_done_n;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            cyc();
            hit = ((is_wr ? wr_done_n : rd_done_n) > c0);
        end
        if (is_wr) bus.wr_req = 1'b0;
        else       bus.rd_req = 1'b0;
        check(tag, 128'(hit), 128'd1);
    endtask

    task automatic run_wr(input logic [27:0] a, input logic [7:0] l, input int budget, input string tag);
        cmd_q.delete();
        bus.wr_addr = a;
        bus.wr_len  = l;
        bus.wr_req  = 1'b1;
        wait_done(1'b1, budget, tag);
    endtask

    int c0, p0, d0;

    initial begin
        rst_n = 1'b0;
        bus.init_calib_complete = 1'b0;
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_len = '0;
        bus.rd_req = 1'b0; bus.rd_addr = '0; bus.rd_len = '0;
        bus.wr_data = '0;
        bus.app_rdy = 1'b0; bus.app_wdf_rdy = 1'b0;
        bus.app_rd_data = '0; bus.app_rd_data_valid = 1'b0;
        repeat (2) cyc();

        // reset state
        check("rst_app_en", 128'(bus.app_en), 128'd0);
        check("rst_wdf_wren", 128'(bus.app_wdf_wren), 128'd0);
        check("rst_wr_data_rd", 128'(bus.wr_data_rd), 128'd0);
        check("rst_app_addr", 128'(bus.app_addr), 128'd0);
        check("rst_wr_done", 128'(bus.wr_done), 128'd0);
        rst_n = 1'b1;
        cyc();

        // calibration gate, grant latency
        cmd_q.delete();
        bus.wr_addr = 28'h100;
        bus.wr_len  = 8'd4;
        bus.wr_req  = 1'b1;
        repeat (5) cyc();
        check("calib_low_no_en", 128'(en_seen), 128'd0);
        bus.init_calib_complete = 1'b1;
        cyc();
        check("grant_app_en", 128'(bus.app_en), 128'd1);
        check("grant_app_cmd", 128'(bus.app_cmd), 128'd0);
        check("grant_app_addr", 128'(bus.app_addr), 128'h100);

        // write burst 0x100 x4
        wait_done(1'b1, 50, "wr4_done_seen");
        check("wr4_cmds", 128'(cmd_q.size()), 128'd4);
        for (int i = 0; i < 4 && i < cmd_q.size(); i++)
            check("wr4_addr", 128'(cmd_q[i]), 128'(28'h100 + 28'(8 * i)));
        check("wr4_pops", 128'(pop_n), 128'd4);
        repeat (3) cyc();
        check("wr4_done_once", 128'(wr_done_n), 128'd1);

        // read back 0x100 x4
        rcap.delete();
        bus.rd_addr = 28'h100;
        bus.rd_len  = 8'd4;
        bus.rd_req  = 1'b1;
        wait_done(1'b0, 50, "rd4_done_seen");
        check("rd4_beats", 128'(rcap.size()), 128'd4);
        for (int i = 0; i < 4 && i < rcap.size(); i++)
            check("rd4_data", rcap[i], wpat(i));
        repeat (3) cyc();
        check("rd4_done_once", 128'(rd_done_n), 128'd1);

        // contested requests from reset alternate W,R,W,R
        do_reset();
        ord = '0;
        c0  = wr_done_n + rd_done_n;
        bus.wr_addr = 28'h300; bus.wr_len = 8'd2;
        bus.rd_addr = 28'h100; bus.rd_len = 8'd2;
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
        for (int i = 0; i < 200 && (wr_done_n + rd_done_n - c0) < 4; i++) cyc();
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        check("alternation", 128'(ord), 128'({8'h57, 8'h52, 8'h57, 8'h52}));
        cyc();

        // random back-pressure, len 16
        rand_rdy = 1'b1;
        hold_err = 0;
        p0 = pop_n;
        run_wr(28'h200, 8'd16, 400, "bp16_done_seen");
        rand_rdy = 1'b0;
        check("bp16_cmds", 128'(cmd_q.size()), 128'd16);
        check("bp16_pops", 128'(pop_n - p0), 128'd16);
        check("bp16_addr_held", 128'(hold_err), 128'd0);
        if (cmd_q.size() == 16) begin
            check("bp16_first_addr", 128'(cmd_q[0]), 128'h200);
            check("bp16_last_addr", 128'(cmd_q[15]), 128'h278);
        end

        // zero-length burst: done with no command
        c0 = cmd_n; p0 = pop_n; d0 = wr_done_n;
        run_wr(28'h600, 8'd0, 20, "len0_done_seen");
        check("len0_no_cmd", 128'(cmd_n - c0), 128'd0);
        check("len0_no_pop", 128'(pop_n - p0), 128'd0);
        check("len0_done_cnt", 128'(wr_done_n - d0), 128'd1);

        // address wraps at 2^28
        run_wr(28'hFFF_FFF8, 8'd2, 30, "wrap_done_seen");
        if (cmd_q.size() == 2) check("wrap_addr", 128'(cmd_q[1]), 128'h0);
        else check("wrap_cmds", 128'(cmd_q.size()), 128'd2);

        // maximum length
        p0 = pop_n;
        run_wr(28'h1000, 8'd255, 400, "len255_done_seen");
        check("len255_cmds", 128'(cmd_q.size()), 128'd255);
        check("len255_pops", 128'(pop_n - p0), 128'd255);

        // asynchronous reset mid-burst, then a fresh len 1 burst
        cmd_q.delete();
        c0 = cmd_n;
        bus.wr_addr = 28'h400;
        bus.wr_len  = 8'd8;
        bus.wr_req  = 1'b1;
        for (int i = 0; i < 30 && (cmd_n - c0) < 2; i++) cyc();
        check("mid_cmds_before_rst", 128'(cmd_n - c0), 128'd2);
        rst_n = 1'b0;
        bus.wr_req = 1'b0;
        #1;
        check("async_rst_app_en", 128'(bus.app_en), 128'd0);
        check("async_rst_wdf_wren", 128'(bus.app_wdf_wren), 128'd0);
        check("async_rst_wr_data_rd", 128'(bus.wr_data_rd), 128'd0);
        check("async_rst_app_addr", 128'(bus.app_addr), 128'd0);
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        run_wr(28'h500, 8'd1, 30, "post_rst_done_seen");
        check("post_rst_cmds", 128'(cmd_q.size()), 128'd1);
        if (cmd_q.size() == 1) check("post_rst_addr", 128'(cmd_q[0]), 128'h500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
